uart_rx_os: RTL

Oversampling UART receiver: recovers 8N1 frames from an asynchronous serial line using a clk-domain tick generator, a two-flop input synchronizer and mid-bit majority-free center sampling. It is the robust counterpart to the team's UART transmitter: it runs entirely on `clk` with no derived clocks, rejects start-bit glitches and flags framing errors. It sits between the pad-level `rx` pin and any byte consumer, such as a FIFO or a command decoder.

---
 rtl/uart_rx_os.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver on clk. It uses a free-running tick divider,
// a two-flop input synchronizer and centre sampling of every bit.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | line idle; look for a low rxs on each tick
//   ST_START | confirm the start bit at its centre (rejects short glitches)
//   ST_DATA  | sample 8 data bits LSB-first, one per OVERSAMPLE ticks
//   ST_STOP  | sample the stop bit; publish the byte or flag a framing error
//   ST_BREAK | stop bit was low; wait for the line to return high
module uart_rx_os #(
  parameter int CLK_FREQ   = 1000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST    = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF_M1 = OS_W'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t           state_q, state_d;
  logic             rx_meta_q, rxs_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic             tick;
  logic [OS_W-1:0]  os_q, os_d;
  logic [2:0]       bitn_q, bitn_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  // Free-running sample-tick divider, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else if (div_cnt_q == DIV_LAST) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + DIV_W'(1);
    end
  end

  assign tick = (div_cnt_q == DIV_LAST);

  // Receiver state, counters, data and output pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      os_q    <= '0;
      bitn_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      os_q    <= os_d;
      bitn_q  <= bitn_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic; all sampling happens on ticks only.
  always_comb begin
    state_d = state_q;
    os_d    = os_q;
    bitn_d  = bitn_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick && !rxs_q) begin
          state_d = ST_START;
          os_d    = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (os_q == OS_HALF_M1) begin
            os_d = '0;
            if (!rxs_q) begin
              state_d = ST_DATA;
              bitn_d  = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            os_d = os_q + OS_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (os_q == OS_LAST) begin
            os_d    = '0;
            shift_d = {rxs_q, shift_q[7:1]};
            if (bitn_q == 3'd7) begin
              state_d = ST_STOP;
            end else begin
              bitn_d = bitn_q + 3'd1;
            end
          end else begin
            os_d = os_q + OS_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (os_q == OS_LAST) begin
            os_d = '0;
            if (rxs_q) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = ST_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = ST_BREAK;
            end
          end else begin
            os_d = os_q + OS_W'(1);
          end
        end
      end
      ST_BREAK: begin
        if (tick && rxs_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
